// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the debug-port blocks: dump FSM states,
// word geometry and the width of the word counter.
package cpu_dbg_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WC_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/dbg_byte_serializer.sv
// Holds one instruction word and streams it out little-endian, one byte
// per valid/ready handshake; flags the handshake of the final byte.
module dbg_byte_serializer
  import cpu_dbg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] word_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            last
);

  logic [XLEN-1:0] word_q;
  logic [1:0]      idx_q;
  logic            valid_q;

  // Word register, byte index and valid flag; a load restarts at byte 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word_in;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  // Byte select is held stable while stalled; the bus reads zero when idle.
  always_comb begin
    out_valid = valid_q;
    out_data  = valid_q ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
    last      = valid_q && out_ready && (idx_q == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_dumper.sv
// Reads a range of instruction memory through the debug read port and
// streams it out as little-endian bytes. One read is in flight at most.
module imem_dumper
  import cpu_dbg_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] base_addr,
  input  logic [WC_W-1:0] word_count,
  output logic            dbg_rd_en,
  output logic [XLEN-1:0] dbg_rd_addr,
  input  logic [XLEN-1:0] dbg_rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            busy,
  output logic            done
);

  dump_state_t     state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [WC_W-1:0] remain_q;
  logic [2:0]      lat_q;
  logic            done_q;
  logic            load;
  logic            last;

  dbg_byte_serializer #(.XLEN(XLEN)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word_in   (dbg_rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .last      (last)
  );

  // State, address, remaining-word and latency counters; done is a
  // registered pulse issued the cycle after FINISH, when busy is already low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      lat_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FINISH);
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= word_count;
          end
        end
        REQ:  lat_q <= 3'd1;
        WAIT: lat_q <= lat_q + 3'd1;
        SEND: begin
          if (last) begin
            remain_q <= remain_q - WC_W'(1);
            addr_q   <= addr_q + XLEN'(4);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode plus the read strobe and serializer load.
  always_comb begin
    state_d   = state_q;
    dbg_rd_en = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (word_count == '0) ? FINISH : REQ;
      end
      REQ: begin
        dbg_rd_en = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_q == 3'(RD_LATENCY)) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last) state_d = (remain_q == WC_W'(1)) ? FINISH : REQ;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbg_rd_addr = addr_q;
  assign busy        = (state_q == REQ) || (state_q == WAIT) || (state_q == SEND);
  assign done        = done_q;

endmodule

// File: tb/tb_imem_dumper.sv
// Directed bench for imem_dumper: one instance at read latency 1 and one
// at latency 3 for the address-wrap case, each fed by a small memory model.
module tb_imem_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, out_ready;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        dbg_rd_en, out_valid, busy, done;
  logic [31:0] dbg_rd_addr, dbg_rd_data;
  logic [7:0]  out_data;

  logic        b_start, b_ready;
  logic [31:0] b_base;
  logic [15:0] b_count;
  logic        b_rd_en, b_valid, b_busy, b_done;
  logic [31:0] b_rd_addr, b_rd_data;
  logic [7:0]  b_data;

  logic [31:0] mem [16];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  bytes_a [$];
  logic [7:0]  bytes_b [$];
  logic [31:0] addrs_a [$];
  logic [31:0] addrs_b [$];
  int   done_cnt, done_cyc, hs_cnt, valid_cnt, b_done_cnt;
  logic busy_at_done;
  logic stall_prev;
  logic [7:0] data_prev;

  imem_dumper #(.XLEN(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .dbg_rd_en(dbg_rd_en), .dbg_rd_addr(dbg_rd_addr),
    .dbg_rd_data(dbg_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  imem_dumper #(.XLEN(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base),
    .word_count(b_count), .dbg_rd_en(b_rd_en), .dbg_rd_addr(b_rd_addr),
    .dbg_rd_data(b_rd_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .busy(b_busy), .done(b_done)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: data is only meaningful exactly at the read latency,
  // every other cycle shows a poison word.
  always @(posedge clk) begin
    pipe_a    <= dbg_rd_en ? mem[dbg_rd_addr[5:2]] : 32'hDEAD_BEEF;
    pipe_b[0] <= b_rd_en ? mem[b_rd_addr[5:2]] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign dbg_rd_data = pipe_a;
  assign b_rd_data   = pipe_b[2];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: collects bytes, read addresses and done pulses; checks stalls
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        bytes_a.push_back(out_data);
        hs_cnt++;
      end
      if (out_valid) valid_cnt++;
      if (dbg_rd_en) begin
        addrs_a.push_back(dbg_rd_addr);
        check_output("rd_while_valid", {31'd0, out_valid}, 32'd0);
      end
      if (stall_prev) begin
        check_output("stall_valid", {31'd0, out_valid}, 32'd1);
        check_output("stall_data", {24'd0, out_data}, {24'd0, data_prev});
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (b_valid && b_ready) bytes_b.push_back(b_data);
      if (b_rd_en) addrs_b.push_back(b_rd_addr);
      if (b_done) b_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bytes_a.delete();
    addrs_a.delete();
    done_cnt     = 0;
    done_cyc     = 0;
    hs_cnt       = 0;
    valid_cnt    = 0;
    busy_at_done = 1'bx;
  endtask

  task automatic apply_stimulus(input logic [31:0] base, input logic [15:0] cnt,
                                input bit rand_ready, output int start_cyc);
    int n;
    clear_mon();
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    start_cyc  = cyc;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 3);
      tick();
      n++;
    end
    check_output("done_timeout", {31'd0, done_cnt != 0}, 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check_output("done_once", done_cnt, 1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp [$]);
    logic [7:0] got;
    check_output({tag, "_len"}, bytes_a.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bytes_a.size()) ? bytes_a[i] : 8'hxx;
      check_output($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    logic [7:0] exp [$];
    int s;
    int n;

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    b_start = 1'b0; b_base = '0; b_count = '0; b_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    stall_prev = 1'b0;
    clear_mon();
    b_done_cnt = 0;
    tick(); tick(); tick();

    // Reset values
    check_output("rst_rd_en", {31'd0, dbg_rd_en}, 0);
    check_output("rst_rd_addr", dbg_rd_addr, 0);
    check_output("rst_valid", {31'd0, out_valid}, 0);
    check_output("rst_data", {24'd0, out_data}, 0);
    check_output("rst_busy", {31'd0, busy}, 0);
    check_output("rst_done", {31'd0, done}, 0);
    check_output("rst_b_busy", {31'd0, b_busy}, 0);
    check_output("rst_b_done", {31'd0, b_done}, 0);
    rst = 1'b0;
    tick();

    // Single word
    mem[0] = 32'h0011_0193;
    apply_stimulus(32'h0, 16'd1, 1'b0, s);
    exp = '{8'h93, 8'h01, 8'h11, 8'h00};
    check_bytes("one", exp);
    check_output("one_busy_at_done", {31'd0, busy_at_done}, 0);
    check_output("one_addr", (addrs_a.size() > 0) ? addrs_a[0] : 32'hxxxx_xxxx, 32'h0);

    // Three words
    mem[0] = 32'h0011_2193; mem[1] = 32'h0011_3193; mem[2] = 32'h0011_7193;
    apply_stimulus(32'h0, 16'd3, 1'b0, s);
    exp = '{8'h93, 8'h21, 8'h11, 8'h00, 8'h93, 8'h31, 8'h11, 8'h00,
            8'h93, 8'h71, 8'h11, 8'h00};
    check_bytes("three", exp);
    check_output("three_nrd", addrs_a.size(), 3);
    for (int i = 0; i < 3; i++)
      check_output($sformatf("three_addr%0d", i),
                   (i < addrs_a.size()) ? addrs_a[i] : 32'hxxxx_xxxx, 32'(4 * i));

    // Zero words
    apply_stimulus(32'h40, 16'd0, 1'b0, s);
    check_output("zero_done_delay", done_cyc - s, 2);
    check_output("zero_nrd", addrs_a.size(), 0);
    check_output("zero_nvalid", valid_cnt, 0);

    // Four words, ready high then random stalls
    mem[0] = 32'h1122_3344; mem[1] = 32'h5566_7788;
    mem[2] = 32'h99AA_BBCC; mem[3] = 32'hDDEE_FF00;
    exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
            8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h00, 8'hFF, 8'hEE, 8'hDD};
    apply_stimulus(32'h0, 16'd4, 1'b0, s);
    check_bytes("four_rdy", exp);
    apply_stimulus(32'h0, 16'd4, 1'b1, s);
    check_bytes("four_rand", exp);

    // Reset in the middle of word 1, byte 2, with start held alongside reset
    clear_mon();
    start = 1'b1; base_addr = 32'h0; word_count = 16'd3;
    tick();
    start = 1'b0;
    n = 0;
    while (hs_cnt < 6 && n < 200) begin
      tick();
      n++;
    end
    check_output("abort_reach", hs_cnt, 6);
    rst = 1'b1; start = 1'b1; out_ready = 1'b0; base_addr = 32'h4; word_count = 16'd1;
    tick();
    check_output("abort_rd_en", {31'd0, dbg_rd_en}, 0);
    check_output("abort_rd_addr", dbg_rd_addr, 0);
    check_output("abort_valid", {31'd0, out_valid}, 0);
    check_output("abort_data", {24'd0, out_data}, 0);
    check_output("abort_busy", {31'd0, busy}, 0);
    check_output("abort_done", {31'd0, done}, 0);
    tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check_output("start_with_rst_ignored", {31'd0, busy}, 0);
    check_output("no_done_on_abort", done_cnt, 0);
    apply_stimulus(32'h8, 16'd1, 1'b0, s);
    exp = '{8'hCC, 8'hBB, 8'hAA, 8'h99};
    check_bytes("after_abort", exp);

    // Address wrap at read latency 3
    mem[15] = 32'hA1B2_C3D4; mem[0] = 32'h0F1E_2D3C;
    bytes_b.delete(); addrs_b.delete(); b_done_cnt = 0;
    b_start = 1'b1; b_base = 32'hFFFF_FFFC; b_count = 16'd2;
    tick();
    b_start = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check_output("wrap_done", b_done_cnt, 1);
    check_output("wrap_nrd", addrs_b.size(), 2);
    check_output("wrap_addr0", (addrs_b.size() > 0) ? addrs_b[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    check_output("wrap_addr1", (addrs_b.size() > 1) ? addrs_b[1] : 32'hxxxx_xxxx, 32'h0);
    exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    check_output("wrap_len", bytes_b.size(), 8);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("wrap_b%0d", i),
                   {24'd0, (i < bytes_b.size()) ? bytes_b[i] : 8'hxx}, {24'd0, exp[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_dumper.md
IMEM_DUMPER -- requirements
Module: imem_dumper

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the instruction word and address width.
REQ-002 SHALL have parameter RD_LATENCY, default 1, giving the cycles from dbg_rd_en to valid dbg_rd_data (range 1-4).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a dump.
REQ-006 SHALL have port base_addr  input  XLEN  byte address of the first word, sampled on start.
REQ-007 SHALL have port word_count  input  16  number of words to dump, sampled on start.
REQ-008 SHALL have port dbg_rd_en  output  1  instruction-memory debug read strobe.
REQ-009 SHALL have port dbg_rd_addr  output  XLEN  instruction-memory debug read byte address.
REQ-010 SHALL have port dbg_rd_data  input  XLEN  read data, valid RD_LATENCY cycles after dbg_rd_en.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-013 SHALL have port out_data  output  8  streamed byte.
REQ-014 SHALL have port busy  output  1  high from the cycle after start until the return to IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the dump completes.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, SEND, FINISH.
REQ-017 IDLE: a start pulse latches base_addr and word_count; count 0 goes to FINISH, otherwise to REQ.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 REQ: assert dbg_rd_en for exactly one cycle with dbg_rd_addr = current address, then go to WAIT.
REQ-020 WAIT: count RD_LATENCY cycles, capture dbg_rd_data into a word register on the last one, then go to SEND with byte index 0.
REQ-021 SEND: drive bytes little-endian (index 0 = bits 7:0 ... index 3 = bits 31:24); out_valid stays high and out_data stays stable until out_valid & out_ready.
REQ-022 A handshake on byte 3 SHALL decrement the remaining count and add 4 to the address (wrap modulo 2^XLEN); the FSM goes to REQ if words remain, else FINISH.
REQ-023 FINISH: pulse done for one cycle with busy low, then go to IDLE.
REQ-024 The throughput floor with out_ready tied high SHALL be one word per 1+RD_LATENCY+4 cycles.
REQ-025 dbg_rd_en SHALL never be asserted while out_valid is high; there are no outstanding reads.
REQ-026 out_ready low for any number of cycles SHALL stall without loss or duplication of bytes.
REQ-027 word_count 0xFFFF SHALL dump 65535 words; address wrap from 0xFFFFFFFC SHALL continue at 0x0.

Reset
REQ-028 rst high SHALL force IDLE on the next edge regardless of state and abort any in-progress dump without a done pulse.
REQ-029 During and after reset: dbg_rd_en=0, dbg_rd_addr=0, out_valid=0, out_data=0, busy=0, done=0, and internal counters and the word register cleared.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-031 The shared package cpu_dbg_pkg SHALL hold the FSM state enum, BYTES_PER_WORD=4, and the word_count width constant.
REQ-032 One sub-module, dbg_byte_serializer (word in, valid/ready byte out, last flag), SHALL implement SEND; the FSM and address/count logic stay in imem_dumper.

Verification
REQ-033 Memory[0]=0x00110193; start, base 0, count 1, out_ready=1 -> bytes 0x93,0x01,0x11,0x00, then one done pulse, busy low.
REQ-034 Memory[0..8] = 0x00112193, 0x00113193, 0x00117193; count 3 -> 12 bytes in order, dbg_rd_addr sequence 0,4,8.
REQ-035 count 0 -> no dbg_rd_en and no out_valid, done exactly 2 cycles after start.
REQ-036 out_ready toggled randomly 30% high over a 4-word dump -> byte stream identical to the out_ready=1 run, out_data stable while stalled.
REQ-037 rst asserted on byte 2 of word 1 -> all outputs at reset values next cycle, no done; a new start afterwards dumps correctly.
REQ-038 base 0xFFFFFFFC, count 2, RD_LATENCY=3 -> reads at 0xFFFFFFFC then 0x0, each read's data captured 3 cycles after its strobe.
